// File: rtl/riscv_core_pkg.sv
// Shared core types for the memory issue path: active-list index, op record and age helper.
// Active-list depth comes from the `AL_SIZE macro (defaults to 64 when not supplied).
`ifndef AL_SIZE
`define AL_SIZE 64
`endif

package riscv_core_pkg;

   localparam int AL_IDX_W      = $clog2(`AL_SIZE);
   localparam int MEM_PAYLOAD_W = 96;

   typedef logic [AL_IDX_W-1:0] al_idx_t;

   typedef struct packed {
      al_idx_t                  al_addr;
      logic [MEM_PAYLOAD_W-1:0] payload;
   } mem_op_t;

   // Distance from the oldest active-list entry; wraps naturally at AL_SIZE.
   function automatic al_idx_t al_age(input al_idx_t idx, input al_idx_t front);
      return idx - front;
   endfunction

endpackage

// File: rtl/mem_arb_skid_fifo.sv
// Per-bank skid FIFO for memory-issue ops: in-order push/pop plus recall tail pullback.
// Survivors of a recall are always a prefix from the head, so only the count shrinks.
module mem_arb_skid_fifo
   import riscv_core_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int PAYLOAD_W = MEM_PAYLOAD_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  al_idx_t              push_al,
   input  logic [PAYLOAD_W-1:0] push_payload,
   input  logic                 pop,
   input  logic                 recall,
   input  al_idx_t              old_front,
   input  al_idx_t              new_front,
   output logic                 full,
   output logic                 empty,
   output al_idx_t              head_al,
   output logic [PAYLOAD_W-1:0] head_payload
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     keep;
   al_idx_t              kill_age;
   al_idx_t              al_mem  [DEPTH];
   logic [PAYLOAD_W-1:0] pay_mem [DEPTH];

   // Length of the surviving prefix: stop at the first entry at or beyond new_front.
   always_comb begin
      kill_age = al_age(new_front, old_front);
      keep     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) && (keep == CNT_W'(i)) &&
             (al_age(al_mem[rd_ptr + PTR_W'(i)], old_front) < kill_age))
            keep = CNT_W'(i + 1);
      end
   end

   assign wr_ptr       = rd_ptr + (recall ? keep[PTR_W-1:0] : count[PTR_W-1:0]);
   assign full         = (count == CNT_W'(DEPTH));
   assign empty        = (count == '0);
   assign head_al      = al_mem[rd_ptr];
   assign head_payload = pay_mem[rd_ptr];

   // The arbiter never pops in a recall cycle, so recall only rewrites the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         count  <= '0;
      end else if (recall) begin
         count <= keep + CNT_W'(push);
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         al_mem[wr_ptr]  <= push_al;
         pay_mem[wr_ptr] <= push_payload;
      end
   end

endmodule

// File: rtl/mem_issue_arbiter.sv
// Two-bank memory-issue arbiter: oldest-first select over skid-FIFO heads into a registered port.
// Define MEM_ARB_PERF_EN to add saturating conflict/full performance counters.
`ifndef AL_SIZE
`define AL_SIZE 64
`endif

module mem_issue_arbiter
   import riscv_core_pkg::*;
#(
   parameter int AL_SIZE    = `AL_SIZE,
   parameter int PAYLOAD_W  = MEM_PAYLOAD_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               ext_stall,
   input  logic [1:0]                         in_valid,
   output logic [1:0]                         in_ready,
   input  logic [1:0][$clog2(AL_SIZE)-1:0]    in_al_addr,
   input  logic [1:0][PAYLOAD_W-1:0]          in_payload,
   input  logic                               if_recall,
   input  logic [$clog2(AL_SIZE)-1:0]         old_front,
   input  logic [$clog2(AL_SIZE)-1:0]         new_front,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [$clog2(AL_SIZE)-1:0]         out_al_addr,
   output logic [PAYLOAD_W-1:0]               out_payload,
   output logic                               out_bank
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]                        perf_conflict_cnt,
   output logic [31:0]                        perf_full_cnt
`endif
);

   logic [1:0]                fifo_full;
   logic [1:0]                fifo_empty;
   logic [1:0]                head_vld;
   logic [1:0]                push;
   logic [1:0]                pop;
   al_idx_t                   head_al      [2];
   al_idx_t                   head_age     [2];
   logic [PAYLOAD_W-1:0]      head_payload [2];
   al_idx_t                   kill_age;
   logic                      sel;
   logic                      load;
   logic                      out_fire;
   logic                      run;

   logic                      vld_p1;
   al_idx_t                   al_p1;
   logic [PAYLOAD_W-1:0]      pay_p1;
   logic                      bank_p1;

   assign kill_age = al_age(new_front, old_front);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign head_vld[b] = ~fifo_empty[b];
      assign head_age[b] = al_age(head_al[b], old_front);
      assign in_ready[b] = run & ~fifo_full[b];
      // Incoming ops on the wrong path are dropped rather than enqueued.
      assign push[b]     = in_valid[b] & in_ready[b] &
                           ~(if_recall & (al_age(in_al_addr[b], old_front) >= kill_age));
      assign pop[b]      = load & (sel == 1'(b));

      mem_arb_skid_fifo #(
         .DEPTH     (FIFO_DEPTH),
         .PAYLOAD_W (PAYLOAD_W)
      ) u_fifo (
         .clk          (clk),
         .reset        (reset),
         .push         (push[b]),
         .push_al      (in_al_addr[b]),
         .push_payload (in_payload[b]),
         .pop          (pop[b]),
         .recall       (if_recall),
         .old_front    (old_front),
         .new_front    (new_front),
         .full         (fifo_full[b]),
         .empty        (fifo_empty[b]),
         .head_al      (head_al[b]),
         .head_payload (head_payload[b])
      );
   end

   // Bank 1 wins only when strictly older; ties fall to bank 0.
   assign sel      = head_vld[1] & (~head_vld[0] | (head_age[1] < head_age[0]));
   assign out_fire = vld_p1 & out_ready & ~ext_stall;
   assign load     = ~ext_stall & ~if_recall & (~vld_p1 | out_ready) & (|head_vld);

   // Holds in_ready low from reset assertion until the first clock after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         run <= 1'b0;
      else
         run <= 1'b1;
   end

   // ---- stage p1: registered issue port ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1  <= 1'b0;
         al_p1   <= '0;
         pay_p1  <= '0;
         bank_p1 <= 1'b0;
      end else if (if_recall) begin
         if (vld_p1 && (out_fire || (al_age(al_p1, old_front) >= kill_age)))
            vld_p1 <= 1'b0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         al_p1   <= head_al[sel];
         pay_p1  <= head_payload[sel];
         bank_p1 <= sel;
      end else if (out_fire) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid   = vld_p1;
   assign out_al_addr = al_p1;
   assign out_payload = pay_p1;
   assign out_bank    = bank_p1;

`ifdef MEM_ARB_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_conflict_cnt <= '0;
         perf_full_cnt     <= '0;
      end else begin
         if (load && (&head_vld))
            perf_conflict_cnt <= sat_inc(perf_conflict_cnt);
         if (|(in_valid & ~in_ready))
            perf_full_cnt <= sat_inc(perf_full_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_mem_issue_arbiter.sv
// Bench for mem_issue_arbiter: arbitration vector table plus backpressure, recall, stall and reset sequences.
// Issued ops are checked in order against a queue of expected {al, bank, payload} records.
module tb_mem_issue_arbiter;

   localparam int AW = 6;
   localparam int PW = 96;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 ext_stall;
   logic [1:0]           in_valid;
   logic [1:0]           in_ready;
   logic [1:0][AW-1:0]   in_al_addr;
   logic [1:0][PW-1:0]   in_payload;
   logic                 if_recall;
   logic [AW-1:0]        old_front;
   logic [AW-1:0]        new_front;
   logic                 out_valid;
   logic                 out_ready;
   logic [AW-1:0]        out_al_addr;
   logic [PW-1:0]        out_payload;
   logic                 out_bank;

   always #5 clk = ~clk;

   mem_issue_arbiter #(
      .AL_SIZE    (64),
      .PAYLOAD_W  (PW),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ext_stall   (ext_stall),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_al_addr  (in_al_addr),
      .in_payload  (in_payload),
      .if_recall   (if_recall),
      .old_front   (old_front),
      .new_front   (new_front),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_al_addr (out_al_addr),
      .out_payload (out_payload),
      .out_bank    (out_bank)
   );

   typedef struct packed {
      logic [AW-1:0] al;
      logic          bank;
      logic [PW-1:0] pay;
   } exp_t;

   typedef struct {
      logic [1:0]    v;
      logic [AW-1:0] of;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic          first;
   } vec_t;

   exp_t exp_q[$];
   exp_t mon_e;
   vec_t vecs[8];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [PW-1:0] mk_pay(input logic [AW-1:0] al, input logic bank);
      return {16'hC0DE, 10'd0, al, 31'd0, bank, 26'h2AAAAAA, al};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int b, input logic [AW-1:0] al);
      in_al_addr[b] = al;
      in_payload[b] = mk_pay(al, 1'(b));
   endtask

   task automatic expect_op(input logic [AW-1:0] al, input logic bank);
      exp_q.push_back({al, bank, mk_pay(al, bank)});
   endtask

   // Scoreboard: every accepted issue must match the next expected op.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready && !ext_stall) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got al %0d bank %0d, expected no issue", out_al_addr, out_bank);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_order", 128'({out_al_addr, out_bank, out_payload}), 128'(mon_e));
         end
      end
   end

   initial begin
      reset      = 1'b0;
      ext_stall  = 1'b0;
      in_valid   = 2'b00;
      in_al_addr = '0;
      in_payload = '0;
      if_recall  = 1'b0;
      old_front  = '0;
      new_front  = '0;
      out_ready  = 1'b1;

      vecs[0] = '{2'b01, 6'd0,  6'd5,  6'd0,  1'b0};
      vecs[1] = '{2'b11, 6'd60, 6'd2,  6'd62, 1'b1};
      vecs[2] = '{2'b11, 6'd0,  6'd10, 6'd20, 1'b0};
      vecs[3] = '{2'b11, 6'd0,  6'd20, 6'd10, 1'b1};
      vecs[4] = '{2'b10, 6'd0,  6'd0,  6'd33, 1'b1};
      vecs[5] = '{2'b11, 6'd63, 6'd0,  6'd63, 1'b1};
      vecs[6] = '{2'b11, 6'd0,  6'd7,  6'd7,  1'b0};
      vecs[7] = '{2'b11, 6'd32, 6'd31, 6'd32, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_al", 128'(out_al_addr), 128'(0));
      check("rst_out_payload", 128'(out_payload), 128'(0));
      check("rst_out_bank", 128'(out_bank), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(2'b00));
      reset = 1'b1;
      tick();
      tick();
      check("rel_in_ready", 128'(in_ready), 128'(2'b11));

      // Arbitration table: ops arrive together, first issue one cycle after enqueue.
      for (int i = 0; i < 8; i++) begin
         old_front = vecs[i].of;
         drive(0, vecs[i].a0);
         drive(1, vecs[i].a1);
         in_valid = vecs[i].v;
         if (vecs[i].v == 2'b01)
            expect_op(vecs[i].a0, 1'b0);
         else if (vecs[i].v == 2'b10)
            expect_op(vecs[i].a1, 1'b1);
         else if (vecs[i].first) begin
            expect_op(vecs[i].a1, 1'b1);
            expect_op(vecs[i].a0, 1'b0);
         end else begin
            expect_op(vecs[i].a0, 1'b0);
            expect_op(vecs[i].a1, 1'b1);
         end
         tick();
         in_valid = 2'b00;
         check("vec_lat0_valid", 128'(out_valid), 128'(0));
         tick();
         check("vec_lat1_valid", 128'(out_valid), 128'(1));
         check("vec_first_bank", 128'(out_bank), 128'(vecs[i].first));
         check("vec_first_al", 128'(out_al_addr), 128'(vecs[i].first ? vecs[i].a1 : vecs[i].a0));
         repeat (3) tick();
         check("vec_drain", 128'(exp_q.size()), 128'(0));
      end

      // Backpressure: two FIFO entries plus one held in the output register.
      old_front = 6'd0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("bp_ready_before", 128'(in_ready[0]), 128'(1));
         drive(0, 6'(k + 1));
         in_valid = 2'b01;
         expect_op(6'(k + 1), 1'b0);
         tick();
      end
      in_valid = 2'b00;
      check("bp_full_ready", 128'(in_ready), 128'(2'b10));
      check("bp_out_al", 128'(out_al_addr), 128'(1));
      repeat (3) tick();
      check("bp_out_valid_hold", 128'(out_valid), 128'(1));
      check("bp_payload_stable", 128'(out_payload), 128'(mk_pay(6'd1, 1'b0)));
      out_ready = 1'b1;
      repeat (5) tick();
      check("bp_drain", 128'(exp_q.size()), 128'(0));
      check("bp_ready_after", 128'(in_ready), 128'(2'b11));

      // Recall: output holds 9, FIFO0 holds 3,7; new_front=6 keeps only 3.
      out_ready = 1'b0;
      old_front = 6'd0;
      drive(0, 6'd9);
      in_valid = 2'b01;
      tick();
      drive(0, 6'd3);
      tick();
      drive(0, 6'd7);
      tick();
      in_valid = 2'b00;
      check("rc_out_before", 128'(out_al_addr), 128'(9));
      check("rc_full_before", 128'(in_ready), 128'(2'b10));
      if_recall = 1'b1;
      new_front = 6'd6;
      drive(1, 6'd8);
      in_valid  = 2'b10;
      tick();
      if_recall = 1'b0;
      in_valid  = 2'b00;
      check("rc_out_squashed", 128'(out_valid), 128'(0));
      check("rc_ready_after", 128'(in_ready), 128'(2'b11));
      expect_op(6'd3, 1'b0);
      tick();
      check("rc_survivor_valid", 128'(out_valid), 128'(1));
      check("rc_survivor_al", 128'(out_al_addr), 128'(3));
      out_ready = 1'b1;
      repeat (4) tick();
      check("rc_drain", 128'(exp_q.size()), 128'(0));

      // Recall with new_front == old_front squashes everything.
      out_ready = 1'b0;
      old_front = 6'd20;
      new_front = 6'd20;
      drive(0, 6'd21);
      drive(1, 6'd22);
      in_valid = 2'b11;
      tick();
      in_valid = 2'b00;
      tick();
      check("sa_out_before", 128'(out_al_addr), 128'(21));
      if_recall = 1'b1;
      tick();
      if_recall = 1'b0;
      check("sa_out_squashed", 128'(out_valid), 128'(0));
      out_ready = 1'b1;
      repeat (3) tick();
      check("sa_quiet", 128'(out_valid), 128'(0));
      check("sa_ready", 128'(in_ready), 128'(2'b11));

      // ext_stall holds the output for 4 cycles; release issues the oldest head.
      old_front = 6'd10;
      out_ready = 1'b0;
      drive(0, 6'd20);
      in_valid = 2'b01;
      expect_op(6'd20, 1'b0);
      tick();
      drive(0, 6'd22);
      drive(1, 6'd21);
      in_valid = 2'b11;
      tick();
      in_valid  = 2'b00;
      ext_stall = 1'b1;
      out_ready = 1'b1;
      expect_op(6'd21, 1'b1);
      expect_op(6'd22, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("st_hold_al", 128'(out_al_addr), 128'(20));
         check("st_hold_valid", 128'(out_valid), 128'(1));
      end
      ext_stall = 1'b0;
      tick();
      check("st_release_al", 128'(out_al_addr), 128'(21));
      check("st_release_bank", 128'(out_bank), 128'(1));
      repeat (4) tick();
      check("st_drain", 128'(exp_q.size()), 128'(0));

      // Asynchronous reset mid-burst: in-flight ops are lost.
      out_ready = 1'b0;
      old_front = 6'd0;
      drive(0, 6'd1);
      drive(1, 6'd2);
      in_valid = 2'b11;
      tick();
      tick();
      in_valid = 2'b00;
      check("ar_busy_valid", 128'(out_valid), 128'(1));
      #2;
      reset = 1'b0;
      #1;
      check("ar_out_valid", 128'(out_valid), 128'(0));
      check("ar_out_al", 128'(out_al_addr), 128'(0));
      check("ar_in_ready", 128'(in_ready), 128'(2'b00));
      #3;
      reset = 1'b1;
      tick();
      tick();
      check("ar_ready_after", 128'(in_ready), 128'(2'b11));
      out_ready = 1'b1;
      repeat (3) tick();
      check("ar_fifos_empty", 128'(out_valid), 128'(0));

      check("final_queue_empty", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_issue_arbiter.md
Name: mem_issue_arbiter

Overview:
- Sits directly downstream of the two-bank in-order issue queue.
- Consumes the two per-bank memory-issue streams and buffers each in a 2-entry skid FIFO.
- Each cycle it selects the oldest ready op by active-list age and presents it through a registered single-port output to the memory pipeline.
- Squashes wrong-path ops on branch recall.

Parameters:
- AL_SIZE, `AL_SIZE, active-list depth (power of 2)
- PAYLOAD_W, 96, opaque op payload width (opcode, preg tags, imm)
- FIFO_DEPTH, 2, per-bank skid-FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- ext_stall  in  1  global pipeline stall; no dequeue to output while high
- in_valid  in  2  per-bank op valid
- in_ready  out  2  per-bank can-accept
- in_al_addr  in  2×$clog2(AL_SIZE)  per-bank active-list index
- in_payload  in  2×PAYLOAD_W  per-bank op payload
- if_recall  in  1  branch recall this cycle
- old_front  in  $clog2(AL_SIZE)  oldest active-list entry (age base)
- new_front  in  $clog2(AL_SIZE)  first squashed index on recall
- out_valid  out  1  registered op valid
- out_ready  in  1  memory pipe accepts
- out_al_addr  out  $clog2(AL_SIZE)  issued op AL index
- out_payload  out  PAYLOAD_W  issued op payload
- out_bank  out  1  source bank of issued op

Behaviour:
- Reset: FIFOs empty, out_valid=0, out_al_addr=0, out_payload=0, out_bank=0, in_ready=2'b11 after reset release (0 while reset asserted).
- Input handshake: bank b enqueues on in_valid[b] && in_ready[b]. in_ready[b] = FIFO b not full, registered-free (depends only on occupancy), so a full FIFO deasserts it the cycle after the fill.
- Age: age(x) = (x − old_front) mod AL_SIZE, width $clog2(AL_SIZE), natural wrap. Smaller age = older.
- Select: candidates are FIFO heads. If both valid, pick the smaller age; on equal age (illegal) pick bank 0. If one valid, pick it.
- Output register loads when !ext_stall && (!out_valid || out_ready) && a candidate exists. Head pops that same cycle. Latency enqueue→out_valid = 1 cycle minimum (FIFO write at edge N, out reg at edge N+1).
- Output stays stable while out_valid && !out_ready, or while ext_stall.
- Recall (if_recall=1): any entry with age(al_addr) ≥ age(new_front) is squashed.
  - Applies to FIFO entries, the output register and same-cycle incoming ops (those are not enqueued).
  - Survivors keep order; FIFO is compacted (implement as tail pullback: entries younger than new_front are contiguous at the tail in-order).
  - No op is loaded into the output register in the recall cycle.
  - new_front == old_front squashes everything.
- Simultaneous enqueue + dequeue on a full FIFO: enqueue is not allowed (in_ready already 0); on a non-full FIFO both occur, occupancy unchanged.
- Reset assertion mid-operation: all state cleared immediately (async); in-flight ops are lost.

Optional Feature:
- MEM_ARB_PERF_EN defined: adds outputs perf_conflict_cnt[31:0] and perf_full_cnt[31:0].
  - perf_conflict_cnt counts cycles both heads were valid and a load occurred.
  - perf_full_cnt counts cycles either in_ready=0 with its in_valid=1.
  - Both saturate at 2^32−1 and reset to 0.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared package riscv_core_pkg:
  - al_idx_t typedef ($clog2(`AL_SIZE) bits)
  - mem_op_t payload struct
  - function al_age(idx, front) returning the modular difference
- Natural sub-module: mem_arb_skid_fifo (one per bank), which provides push/pop/full/empty, head outputs and recall tail-pullback.
- Arbiter, age compare and output register stay in the top module.

Test Plan:
- Single op: bank0 in_valid with al_addr=5, old_front=0 → out_valid=1 one cycle later, out_al_addr=5, out_bank=0.
- Age select with wrap: old_front=60, AL_SIZE=64, bank0 al=2, bank1 al=62 arrive together → bank1 (age 2) issues first, then bank0 (age 6).
- Backpressure: out_ready=0, bank0 pushes 3 ops → in_ready[0]=0 after 2 FIFO fills plus 1 held in output; out_payload stable; on out_ready=1 the ops drain in order.
- Recall: FIFO0 holds al 3,7, output holds al 9, old_front=0, new_front=6, if_recall=1 → out_valid=0 next cycle, only al 3 remains and then issues.
- ext_stall=1 for 4 cycles with both FIFOs non-empty → no dequeue, out register unchanged; stall release → oldest issues next cycle.
- Async reset: drop reset to 0 mid-burst, asynchronous to clk → out_valid=0 and FIFOs empty immediately; after release, in_ready=2'b11.
